seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl_pkg.sv | 12 +
 rtl/seg_scan_ctrl_dec2to4_onehot.sv | 9 +
 rtl/seg_scan_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/seg_scan_ctrl_dec2to4_onehot.sv
// 2-bit index to 4-bit one-hot decoder used to build the anode pattern.
module dec2to4_onehot (
  input  logic [1:0] idx,
  output logic [3:0] onehot_c
);

  assign onehot_c = 4'(4'b0001 << idx);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: drives the nibble-mux select and
// active-low anodes, with a blank interval at the start of every digit slot.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_mask,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       sel_d;
  logic [3:0]       an_d;
  logic             frame_tick_d;
  logic [3:0]       sel_oh_c;

  dec2to4_onehot u_dec (
    .idx      (sel),
    .onehot_c (sel_oh_c)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mask_q     <= '0;
      sel        <= 2'd0;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      sel        <= sel_d;
      an         <= an_d;
      frame_tick <= frame_tick_d;
    end
  end

  // Next-state and next-output logic; sel only moves on entry to BLANK
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    sel_d        = sel;
    an_d         = an;
    frame_tick_d = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = 2'd0;
      an_d    = AN_OFF;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          sel_d   = 2'd0;
          an_d    = AN_OFF;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          an_d  = AN_OFF;
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            mask_d  = digit_mask;
            an_d    = ~(sel_oh_c & digit_mask);
          end
        end
        SHOW: begin
          cnt_d = cnt_q + CNT_W'(1);
          an_d  = ~(sel_oh_c & mask_q);
          if (cnt_q == SLOT_LAST) begin
            state_d      = BLANK;
            cnt_d        = '0;
            sel_d        = sel + 2'd1;
            an_d         = AN_OFF;
            frame_tick_d = (sel == 2'd3);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = 2'd0;
          an_d    = AN_OFF;
        end
      endcase
    end
  end

endmodule
